// File: rtl/fir_loader_pkg.sv
// Shared definitions for the FIR coefficient loader: frame header, FSM states,
// error codes and the coefficient byte-count helper.
package fir_loader_pkg;

   localparam logic [7:0] HDR = 8'hC5;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_BYTES,
      ST_WRITE,
      ST_WAIT_ACK,
      ST_VERIFY,
      ST_NEXT,
      ST_SHW,
      ST_SHACK,
      ST_FLUSH,
      ST_DONE
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_SHIFT   = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;
   localparam logic [1:0] ERR_VERIFY  = 2'b11;

   function automatic int bytes_for(input int width);
      return (width + 7) / 8;
   endfunction

endpackage

// File: rtl/coef_byte_packer.sv
// Shifts host bytes MSB-first into a coef_width word; full_o flags that the
// next pushed byte completes the word, after which the count wraps to zero.
module coef_byte_packer
   import fir_loader_pkg::*;
#(
   parameter int coef_width = 24
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear_i,
   input  logic                  push_i,
   input  logic [7:0]            byte_i,
   output logic [coef_width-1:0] word_o,
   output logic                  full_o
);

   localparam int CB = bytes_for(coef_width);
   localparam int CW = (CB > 1) ? $clog2(CB) : 1;
   localparam logic [CW-1:0] LAST = CW'(CB - 1);

   logic [CW-1:0]         cnt_q, cnt_d;
   logic [coef_width-1:0] word_q, word_d;

   assign full_o = (cnt_q == LAST);
   assign word_o = word_q;

   always_comb begin
      cnt_d  = cnt_q;
      word_d = word_q;
      if (clear_i) begin
         cnt_d  = '0;
         word_d = '0;
      end else if (push_i) begin
         // Bits shifted past coef_width fall off the top.
         word_d = coef_width'({word_q, byte_i});
         cnt_d  = full_o ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         word_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         word_q <= word_d;
      end
   end

endmodule

// File: rtl/fir_coef_loader.sv
// Host-framed coefficient/result-shift loader for one fir_filt instance.
// Define FIR_LOADER_VERIFY_EN to build the per-coefficient readback check.
module fir_coef_loader
   import fir_loader_pkg::*;
#(
   parameter int coef_width  = 24,
   parameter int coef_count  = 16,
   parameter int max_shift   = 32,
   parameter int ack_timeout = 15
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [$clog2(coef_count)-1:0] addr,
   output logic [coef_width-1:0]         coef,
   output logic                          coef_ready,
   input  logic                          coef_done,
   input  logic [coef_width-1:0]         coef_r,
   output logic                          result_shift_ready,
   output logic [$clog2(max_shift)-1:0]  result_shift_i,
   input  logic                          result_shift_done,
   output logic                          flush,
   output logic                          busy,
   output logic                          load_done,
   output logic                          err,
   output logic [1:0]                    err_code
);

   localparam int AW = $clog2(coef_count);
   localparam int SW = $clog2(max_shift);
   localparam int TW = $clog2(ack_timeout + 1);
   localparam logic [8:0]    SHIFT_LIM = (max_shift > 256) ? 9'd256 : 9'(max_shift);
   localparam logic [AW-1:0] LAST_ADDR = AW'(coef_count - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(ack_timeout - 1);

   state_t                state_q, state_d;
   logic                  started_q;
   logic [AW-1:0]         addr_q, addr_d;
   logic [SW-1:0]         shift_q, shift_d;
   logic [TW-1:0]         tmo_q, tmo_d;
   logic                  err_q, err_d;
   logic [1:0]            err_code_q, err_code_d;
   logic                  pk_clear, pk_push, pk_full;
   logic [coef_width-1:0] pk_word;
   logic                  fire;

   coef_byte_packer #(
      .coef_width(coef_width)
   ) u_packer (
      .clk    (clk),
      .rst    (rst),
      .clear_i(pk_clear),
      .push_i (pk_push),
      .byte_i (in_data),
      .word_o (pk_word),
      .full_o (pk_full)
   );

   // started_q holds in_ready low for the first cycle after reset release.
   assign in_ready = started_q &&
                     (state_q == ST_IDLE || state_q == ST_SHIFT || state_q == ST_BYTES);
   assign fire               = in_valid && in_ready;
   assign coef_ready         = (state_q == ST_WRITE);
   assign result_shift_ready = (state_q == ST_SHW);
   assign flush              = (state_q == ST_FLUSH);
   assign load_done          = (state_q == ST_DONE);
   assign busy               = (state_q != ST_IDLE);
   assign addr               = addr_q;
   assign coef               = pk_word;
   assign result_shift_i     = shift_q;
   assign err                = err_q;
   assign err_code           = err_code_q;

`ifndef FIR_LOADER_VERIFY_EN
   logic unused_coef_r;
   assign unused_coef_r = ^coef_r;
`endif

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      shift_d    = shift_q;
      tmo_d      = tmo_q;
      err_d      = 1'b0;
      err_code_d = err_code_q;
      pk_clear   = 1'b0;
      pk_push    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (fire && in_data == HDR) begin
               state_d    = ST_SHIFT;
               err_code_d = ERR_NONE;
            end
         end
         ST_SHIFT: begin
            if (fire) begin
               if ({1'b0, in_data} >= SHIFT_LIM) begin
                  err_d      = 1'b1;
                  err_code_d = ERR_SHIFT;
                  state_d    = ST_IDLE;
               end else begin
                  shift_d  = SW'(in_data);
                  addr_d   = '0;
                  pk_clear = 1'b1;
                  state_d  = ST_BYTES;
               end
            end
         end
         ST_BYTES: begin
            if (fire) begin
               pk_push = 1'b1;
               if (pk_full) state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            tmo_d   = '0;
            state_d = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (coef_done) begin
`ifdef FIR_LOADER_VERIFY_EN
               state_d = ST_VERIFY;
`else
               state_d = ST_NEXT;
`endif
            end else if (tmo_q == TMO_LAST) begin
               err_d      = 1'b1;
               err_code_d = ERR_TIMEOUT;
               state_d    = ST_IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
`ifdef FIR_LOADER_VERIFY_EN
         ST_VERIFY: begin
            if (coef_r != pk_word) begin
               err_d      = 1'b1;
               err_code_d = ERR_VERIFY;
               state_d    = ST_IDLE;
            end else begin
               state_d = ST_NEXT;
            end
         end
`endif
         ST_NEXT: begin
            if (addr_q == LAST_ADDR) begin
               state_d = ST_SHW;
            end else begin
               addr_d  = addr_q + AW'(1);
               state_d = ST_BYTES;
            end
         end
         ST_SHW: begin
            tmo_d   = '0;
            state_d = ST_SHACK;
         end
         ST_SHACK: begin
            if (result_shift_done) begin
               state_d = ST_FLUSH;
            end else if (tmo_q == TMO_LAST) begin
               err_d      = 1'b1;
               err_code_d = ERR_TIMEOUT;
               state_d    = ST_IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         ST_FLUSH: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         started_q  <= 1'b0;
         addr_q     <= '0;
         shift_q    <= '0;
         tmo_q      <= '0;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
      end else begin
         state_q    <= state_d;
         started_q  <= 1'b1;
         addr_q     <= addr_d;
         shift_q    <= shift_d;
         tmo_q      <= tmo_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
      end
   end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench for fir_coef_loader with a small fir_filt handshake model.
module tb_fir_coef_loader;

   localparam int CW = 24;
   localparam int CN = 4;
   localparam int MS = 32;
   localparam int AT = 15;
`ifdef FIR_LOADER_VERIFY_EN
   localparam int VER = 1;
`else
   localparam int VER = 0;
`endif

   logic          clk;
   logic          rst;
   logic [7:0]    in_data;
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    addr;
   logic [CW-1:0] coef;
   logic          coef_ready;
   logic          coef_done;
   logic [CW-1:0] coef_r;
   logic          result_shift_ready;
   logic [4:0]    result_shift_i;
   logic          result_shift_done;
   logic          flush;
   logic          busy;
   logic          load_done;
   logic          err;
   logic [1:0]    err_code;

   fir_coef_loader #(
      .coef_width (CW),
      .coef_count (CN),
      .max_shift  (MS),
      .ack_timeout(AT)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .in_data           (in_data),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .addr              (addr),
      .coef              (coef),
      .coef_ready        (coef_ready),
      .coef_done         (coef_done),
      .coef_r            (coef_r),
      .result_shift_ready(result_shift_ready),
      .result_shift_i    (result_shift_i),
      .result_shift_done (result_shift_done),
      .flush             (flush),
      .busy              (busy),
      .load_done         (load_done),
      .err               (err),
      .err_code          (err_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0]    body     [12] = '{8'h12, 8'h34, 8'h56, 8'h00, 8'h00, 8'h01,
                                    8'hFF, 8'hFF, 8'hFF, 8'h80, 8'h00, 8'h00};
   logic [CW-1:0] exp_coef [4]  = '{24'h123456, 24'h000001, 24'hFFFFFF, 24'h800000};

   // Filter model: done one cycle after the strobe, readback two cycles after.
   logic [CW-1:0] mem [CN];
   int            wh_idx   = -1;
   int            flip_idx = -1;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         coef_done         <= 1'b0;
         result_shift_done <= 1'b0;
         coef_r            <= '0;
      end else begin
         coef_done         <= coef_ready && (int'(addr) != wh_idx);
         result_shift_done <= result_shift_ready;
         if (coef_ready) mem[addr] <= coef ^ ((int'(addr) == flip_idx) ? 24'h1 : 24'h0);
         coef_r <= mem[addr];
      end
   end

   int            cyc, wr_n, flush_n, done_n, err_n, shw_n;
   int            flush_cyc, done_cyc, err_cyc, shw_cyc;
   logic [4:0]    shw_val;
   logic [1:0]    log_addr [64];
   logic [CW-1:0] log_coef [64];
   int            log_cyc  [64];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (coef_ready && wr_n < 64) begin
         log_addr[wr_n] <= addr;
         log_coef[wr_n] <= coef;
         log_cyc[wr_n]  <= cyc;
         wr_n           <= wr_n + 1;
      end
      if (result_shift_ready) begin
         shw_n   <= shw_n + 1;
         shw_cyc <= cyc;
         shw_val <= result_shift_i;
      end
      if (flush) begin
         flush_n   <= flush_n + 1;
         flush_cyc <= cyc;
      end
      if (load_done) begin
         done_n   <= done_n + 1;
         done_cyc <= cyc;
      end
      if (err) begin
         err_n   <= err_n + 1;
         err_cyc <= cyc;
      end
   end

   int total, bad;
   int w0, d0, e0, f0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      int n;
      @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      n        = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("in_ready_wait", 32'(in_ready), 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_body(input logic [7:0] sh, input int gap);
      send(sh);
      repeat (gap) @(posedge clk);
      for (int i = 0; i < 12; i++) begin
         send(body[i]);
         repeat (gap) @(posedge clk);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_end(input int dref, input int eref);
      int k;
      k = 0;
      while (done_n == dref && err_n == eref && k < 300) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("end_seen", 32'(k < 300), 1);
      cycles(4);
   endtask

   task automatic check_writes(input int base, input int n);
      for (int k = 0; k < n; k++) begin
         chk("wr_addr", 32'(log_addr[base + k]), k);
         chk("wr_coef", 32'(log_coef[base + k]), 32'(exp_coef[k]));
      end
   endtask

   task automatic chk_reset_outs();
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_addr", 32'(addr), 0);
      chk("rst_coef", 32'(coef), 0);
      chk("rst_coef_ready", 32'(coef_ready), 0);
      chk("rst_shift_ready", 32'(result_shift_ready), 0);
      chk("rst_shift_val", 32'(result_shift_i), 0);
      chk("rst_flush", 32'(flush), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_load_done", 32'(load_done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_err_code", 32'(err_code), 0);
   endtask

   task automatic snap();
      w0 = wr_n;
      d0 = done_n;
      e0 = err_n;
      f0 = flush_n;
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (3) @(negedge clk);
      #1;
      chk_reset_outs();
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("in_ready_rel0", 32'(in_ready), 0);
      @(posedge clk);
      #1;
      chk("in_ready_rel1", 32'(in_ready), 1);

      // Garbage then a clean frame, back-to-back bytes.
      snap();
      send(8'h00);
      send(8'hAA);
      chk("garbage_idle", 32'(busy), 0);
      send(8'hC5);
      chk("busy_hdr", 32'(busy), 1);
      send_body(8'h05, 0);
      wait_end(d0, e0);
      chk("t1_nwr", 32'(wr_n - w0), 4);
      check_writes(w0, 4);
      chk("t1_shift", 32'(shw_val), 5);
      chk("t1_flush", 32'(flush_n - f0), 1);
      chk("t1_done", 32'(done_n - d0), 1);
      chk("t1_noerr", 32'(err_n - e0), 0);
      chk("t1_code", 32'(err_code), 0);
      chk("t1_busy", 32'(busy), 0);
      chk("t1_spacing", 32'(log_cyc[w0 + 1] - log_cyc[w0]), 6 + VER);
      chk("t1_next_shw", 32'(shw_cyc - log_cyc[w0 + 3]), 3 + VER);
      chk("t1_shw_flush", 32'(flush_cyc - shw_cyc), 2);
      chk("t1_shw_done", 32'(done_cyc - shw_cyc), 3);

      // Shift value at the limit.
      snap();
      send(8'hC5);
      send(8'h20);
      cycles(3);
      chk("t2_err", 32'(err_n - e0), 1);
      chk("t2_code", 32'(err_code), 1);
      chk("t2_nwr", 32'(wr_n - w0), 0);
      chk("t2_busy", 32'(busy), 0);
      chk("t2_idle_ready", 32'(in_ready), 1);

      // Max legal shift, gapped input.
      snap();
      send(8'hC5);
      chk("t3_code_clr", 32'(err_code), 0);
      send_body(8'h1F, 3);
      wait_end(d0, e0);
      chk("t3_nwr", 32'(wr_n - w0), 4);
      check_writes(w0, 4);
      chk("t3_shift", 32'(shw_val), 5'h1F);
      chk("t3_done", 32'(done_n - d0), 1);
      chk("t3_code", 32'(err_code), 0);

      // Acknowledge withheld at address 2.
      wh_idx = 2;
      snap();
      send(8'hC5);
      send_body(8'h05, 0);
      wait_end(d0, e0);
      chk("t4_nwr", 32'(wr_n - w0), 3);
      chk("t4_err", 32'(err_n - e0), 1);
      chk("t4_code", 32'(err_code), 2);
      chk("t4_flush", 32'(flush_n - f0), 0);
      chk("t4_done", 32'(done_n - d0), 0);
      chk("t4_tmo_cycles", 32'(err_cyc - log_cyc[w0 + 2]), 16);
      cycles(5);
      chk("t4_code_hold", 32'(err_code), 2);
      wh_idx = -1;

      // Readback corrupted at address 1.
      flip_idx = 1;
      snap();
      send(8'hC5);
      send_body(8'h05, 0);
      wait_end(d0, e0);
      chk("t5_nwr", 32'(wr_n - w0), (VER != 0) ? 2 : 4);
      chk("t5_err", 32'(err_n - e0), VER);
      chk("t5_done", 32'(done_n - d0), 1 - VER);
      chk("t5_code", 32'(err_code), (VER != 0) ? 3 : 0);
      flip_idx = -1;

      // Reset while collecting bytes for address 2.
      snap();
      send(8'hC5);
      send(8'h05);
      for (int i = 0; i < 7; i++) send(body[i]);
      chk("t6_pre_addr", 32'(addr), 2);
      chk("t6_pre_busy", 32'(busy), 1);
      #2;
      rst = 1'b1;
      #1;
      chk_reset_outs();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("t6_rel0", 32'(in_ready), 0);
      @(posedge clk);
      #1;
      chk("t6_rel1", 32'(in_ready), 1);

      snap();
      send(8'hC5);
      send_body(8'h05, 0);
      wait_end(d0, e0);
      chk("t7_nwr", 32'(wr_n - w0), 4);
      check_writes(w0, 4);
      chk("t7_flush", 32'(flush_n - f0), 1);
      chk("t7_done", 32'(done_n - d0), 1);
      chk("t7_code", 32'(err_code), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
